slow_clk_edge_monitor: RTL and testbench

- Consumes a slow square wave, such as the divided 1 Hz clock or an external step/button line, inside the clk_100mhz domain.
- Synchronises the input and emits single-cycle rise/fall strobes usable as clock enables, so logic stays on one clock instead of clocking from a divided clock.
- Measures the rise-to-rise period in fast-clock cycles and flags a stalled source.

---
 rtl/slow_clk_edge_monitor.sv | 140 ++++++++++++++
 tb/tb_slow_clk_edge_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clk_edge_monitor.sv
// Purpose : turns a slow asynchronous square wave into rise/fall clock-enable strobes and measures its period.
// Latency : a slow_in change first sampled at edge k gives a one-cycle strobe from edge k+SYNC_STAGES.
// Backpressure: none; strobes are single-cycle and are not held for a consumer.
//
// Ports:
//   clk_100mhz   - system clock, the only clock domain
//   reset        - asynchronous active-high reset
//   slow_in      - asynchronous slow square wave (divided clock, button, step line)
//   enable       - monitor enable, synchronous to clk_100mhz
//   rise_pulse   - one-cycle strobe per synchronised rising edge (enabled only)
//   fall_pulse   - one-cycle strobe per synchronised falling edge (enabled only)
//   period       - last measured rise-to-rise period in clk_100mhz cycles
//   period_valid - one-cycle strobe when period updates
//   stalled      - level, no rising edge for TIMEOUT cycles
//   edge_count   - wrapping count of rising edges seen while enabled
//
// SYNC_STAGES must be at least 2, and TIMEOUT must fit in CNT_W bits.
module slow_clk_edge_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 27,
   parameter int TIMEOUT     = 100_000_000
) (
   input  logic             clk_100mhz,
   input  logic             reset,
   input  logic             slow_in,
   input  logic             enable,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             stalled,
   output logic [15:0]      edge_count
);

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      STALLED
   } state_t;

   // Counter value on the last cycle before the source counts as stalled.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [CNT_W-1:0]       counter;
   logic                   sync_out;
   logic                   rise;
   logic                   fall;

   // Synchroniser chain plus previous-sample flop. Runs regardless of enable
   // so that re-enabling never sees a stale level as a fresh edge.
   always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev_q;
   assign fall     = ~sync_out & prev_q;

   // Registered strobes and the rising-edge tally, gated by enable.
   always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         edge_count <= 16'd0;
      end else begin
         rise_pulse <= rise & enable;
         fall_pulse <= fall & enable;
         if (rise && enable) begin
            edge_count <= edge_count + 16'd1;
         end
      end
   end

   // Period measurement FSM. The counter holds the number of cycles elapsed
   // since the last rise event minus one, so the reported period is counter+1.
   always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         counter      <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         stalled      <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (!enable) begin
            // period is deliberately retained across a disable.
            state   <= IDLE;
            counter <= '0;
            stalled <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  counter <= '0;
                  stalled <= 1'b0;
                  // First edge only sets the reference point.
                  if (rise) begin
                     state <= MEASURE;
                  end
               end
               MEASURE: begin
                  // A rise coinciding with the last count wins over the stall.
                  if (rise) begin
                     period       <= counter + CNT_W'(1);
                     period_valid <= 1'b1;
                     counter      <= '0;
                  end else if (counter == LAST_CNT) begin
                     state   <= STALLED;
                     stalled <= 1'b1;
                  end else begin
                     counter <= counter + CNT_W'(1);
                  end
               end
               STALLED: begin
                  // Counter holds; the stall gap is not a valid period.
                  if (rise) begin
                     state   <= MEASURE;
                     counter <= '0;
                     stalled <= 1'b0;
                  end
               end
               default: begin
                  state   <= IDLE;
                  counter <= '0;
                  stalled <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_slow_clk_edge_monitor.sv
// Purpose : scoreboard bench for slow_clk_edge_monitor with SYNC_STAGES=2, TIMEOUT=20, CNT_W=5.
// Latency : expected strobes are queued for cycle drive+3 (sampled at edge drive+1, strobe at +2 later).
// Backpressure: none; the monitor pops one expectation per strobe it observes.
module tb_slow_clk_edge_monitor;

   localparam int CNT_W = 5;

   logic             clk_100mhz = 1'b0;
   logic             reset      = 1'b0;
   logic             slow_in    = 1'b1;
   logic             enable     = 1'b1;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             stalled;
   logic [15:0]      edge_count;

   typedef struct {
      int at;
      int val;
   } exp_t;

   exp_t exp_rise[$];
   exp_t exp_pv[$];
   exp_t exp_stall[$];
   int   exp_fall[$];

   int   cyc    = 0;
   int   total  = 0;
   int   bad    = 0;
   int   exp_ec = 0;
   logic last_stalled = 1'b0;
   exp_t mon_e;
   int   mon_f;

   slow_clk_edge_monitor #(
      .SYNC_STAGES(2),
      .CNT_W      (CNT_W),
      .TIMEOUT    (20)
   ) dut (
      .clk_100mhz  (clk_100mhz),
      .reset       (reset),
      .slow_in     (slow_in),
      .enable      (enable),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .period      (period),
      .period_valid(period_valid),
      .stalled     (stalled),
      .edge_count  (edge_count)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   always @(posedge clk_100mhz) cyc <= cyc + 1;

   function automatic exp_t mk(input int at, input int val);
      exp_t e;
      e.at  = at;
      e.val = val;
      return e;
   endfunction

   function automatic void check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, got, want, cyc);
      end
   endfunction

   // Monitor: every strobe or stalled transition must match the oldest expectation.
   always @(negedge clk_100mhz) begin
      if (rise_pulse) begin
         if (exp_rise.size() == 0) check("rise_pulse unexpected at cyc", cyc, -1);
         else begin
            mon_e = exp_rise.pop_front();
            check("rise_pulse cyc", cyc, mon_e.at);
            check("edge_count", int'(edge_count), mon_e.val);
         end
      end
      if (fall_pulse) begin
         if (exp_fall.size() == 0) check("fall_pulse unexpected at cyc", cyc, -1);
         else begin
            mon_f = exp_fall.pop_front();
            check("fall_pulse cyc", cyc, mon_f);
         end
      end
      if (period_valid) begin
         if (exp_pv.size() == 0) check("period_valid unexpected at cyc", cyc, -1);
         else begin
            mon_e = exp_pv.pop_front();
            check("period_valid cyc", cyc, mon_e.at);
            check("period", int'(period), mon_e.val);
         end
      end
      if (stalled !== last_stalled) begin
         if (exp_stall.size() == 0) check("stalled change unexpected at cyc", cyc, -1);
         else begin
            mon_e = exp_stall.pop_front();
            check("stalled cyc", cyc, mon_e.at);
            check("stalled level", int'(stalled), mon_e.val);
         end
         last_stalled = stalled;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_100mhz);
   endtask

   // Called just after a negedge: the new level is first sampled at edge cyc+1.
   task automatic drive(input logic v);
      if (v && !slow_in && enable) begin
         exp_ec++;
         exp_rise.push_back(mk(cyc + 3, exp_ec));
      end
      if (!v && slow_in && enable) exp_fall.push_back(cyc + 3);
      slow_in = v;
   endtask

   // One period: rise, hi cycles high, lo cycles low. pv>0 is the expected period at this rise.
   task automatic wave(input int hi, input int lo, input int pv);
      if (pv > 0) exp_pv.push_back(mk(cyc + 3, pv));
      drive(1'b1);
      step(hi);
      drive(1'b0);
      step(lo);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rise_pulse"}, int'(rise_pulse), 0);
      check({tag, " fall_pulse"}, int'(fall_pulse), 0);
      check({tag, " period"}, int'(period), 0);
      check({tag, " period_valid"}, int'(period_valid), 0);
      check({tag, " stalled"}, int'(stalled), 0);
      check({tag, " edge_count"}, int'(edge_count), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      // Reset held with slow_in high: everything reads zero.
      #1 reset = 1'b1;
      step(3);
      check_all_zero("reset");

      // Release with slow_in still high: one rise from IDLE, no period, then stall 20 cycles later.
      reset  = 1'b0;
      exp_ec = 1;
      exp_rise.push_back(mk(cyc + 3, 1));
      exp_stall.push_back(mk(cyc + 23, 1));
      step(25);
      drive(1'b0);
      step(5);

      // Rise out of STALLED clears stalled without period; the next rise 8 cycles on gives 8.
      exp_stall.push_back(mk(cyc + 3, 0));
      wave(4, 4, 0);
      wave(5, 5, 8);
      wave(5, 5, 10);
      wave(5, 5, 10);

      // 20-cycle spacing: rise on the last count beats the stall.
      wave(10, 10, 10);
      wave(10, 10, 20);
      wave(10, 10, 20);
      wave(10, 11, 20);
      // 21-cycle spacing: stalled high for exactly one cycle, no period update.
      exp_stall.push_back(mk(cyc + 2, 1));
      exp_stall.push_back(mk(cyc + 3, 0));
      wave(5, 5, 0);
      wave(5, 5, 10);
      check("stalled after 21-gap recovery", int'(stalled), 0);
      wave(5, 5, 10);

      // Disable mid-period: rises produce nothing, count and period are frozen.
      enable = 1'b0;
      wave(5, 5, 0);
      wave(5, 5, 0);
      check("edge_count while disabled", int'(edge_count), exp_ec);
      check("period retained while disabled", int'(period), 10);
      check("stalled while disabled", int'(stalled), 0);

      // Re-enable: first rise is a reference only, second gives a period.
      enable = 1'b1;
      wave(5, 5, 0);
      wave(5, 5, 10);

      // Asynchronous reset mid-period clears outputs before the next clock edge.
      exp_pv.push_back(mk(cyc + 3, 10));
      drive(1'b1);
      step(5);
      #2 reset = 1'b1;
      #1 check_all_zero("async reset");
      exp_ec = 0;
      step(1);
      reset  = 1'b0;
      exp_ec = 1;
      exp_rise.push_back(mk(cyc + 3, 1));
      step(5);
      drive(1'b0);
      step(5);
      wave(5, 5, 10);
      step(3);

      check("leftover rise expectations", exp_rise.size(), 0);
      check("leftover fall expectations", exp_fall.size(), 0);
      check("leftover period expectations", exp_pv.size(), 0);
      check("leftover stalled expectations", exp_stall.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
